// File: rtl/lvds_pkg.sv
// Shared constants, types and lane-map decode for the LVDS receive deformatter.
package lvds_pkg;

    localparam int                   WORD_BITS     = 7;
    localparam int                   CNT_W         = $clog2(WORD_BITS);
    localparam logic [WORD_BITS-1:0] ALIGN_PATTERN = 7'b1100011;

    localparam int LANE_A = 3;
    localparam int LANE_B = 2;
    localparam int LANE_C = 1;
    localparam int LANE_D = 0;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lvds_align_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hsync;
        logic       vsync;
        logic       data_en;
    } lvds_pixel_t;

    // Lane D bit 6 carries nothing, so only its low six bits are taken.
    function automatic lvds_pixel_t lvds_unpack(
        input logic [WORD_BITS-1:0] a,
        input logic [WORD_BITS-1:0] b,
        input logic [WORD_BITS-1:0] c,
        input logic [WORD_BITS-2:0] d
    );
        lvds_pixel_t p;
        p.r       = {d[1:0], a[5:0]};
        p.g       = {d[3:2], b[4:0], a[6]};
        p.b       = {d[5:4], c[3:0], b[6:5]};
        p.hsync   = c[4];
        p.vsync   = c[5];
        p.data_en = c[6];
        return p;
    endfunction

endpackage

// File: rtl/lvds_lane_deser.sv
// One serial lane: MSB-first shift register presenting the word that completes this cycle.
module lvds_lane_deser
    import lvds_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_L_i,
    input  logic                 en_i,
    input  logic                 serial_i,
    output logic [WORD_BITS-1:0] word_o
);

    // Only the six most recent bits are ever read back; the seventh is the live input.
    logic [WORD_BITS-2:0] sr_q;
    logic [WORD_BITS-2:0] sr_d;

    assign sr_d   = en_i ? {sr_q[WORD_BITS-3:0], serial_i} : sr_q;
    assign word_o = {sr_q, serial_i};

    always_ff @(posedge clock_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/lvds_data_deformatter.sv
// LVDS receive deformatter: four-lane deserialiser, training-pattern word alignment
// and registered pixel output strobed by pix_valid once locked.
module lvds_data_deformatter
    import lvds_pkg::*;
#(
    parameter int LOCK_COUNT = 4
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       en,
    input  logic [3:0] lane,
    input  logic       train,
    input  logic       realign,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       hsync,
    output logic       vsync,
    output logic       data_en,
    output logic       pix_valid,
    output logic       locked
);

    localparam int                   MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0]   MATCH_ONE  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0]   MATCH_LOCK = MATCH_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(WORD_BITS - 1);

    logic [WORD_BITS-1:0] word_w [4];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        lvds_lane_deser u_deser (
            .clock_i   (clock),
            .reset_L_i (reset_L),
            .en_i      (en),
            .serial_i  (lane[i]),
            .word_o    (word_w[i])
        );
    end

    lvds_align_state_t  state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    lvds_pixel_t        pix_q, pix_d;
    logic               pix_valid_q, pix_valid_d;

    logic               boundary;
    logic               pattern_hit;
    logic               slip;
    logic [MATCH_W-1:0] match_inc;

    assign boundary    = en && (cnt_q == CNT_LAST);
    assign pattern_hit = train && (word_w[LANE_A] == ALIGN_PATTERN);
    // A failed hunt holds the counter so the next enabled bit is a boundary again.
    assign slip        = boundary && !realign && (state_q == HUNT) && train && !pattern_hit;
    assign match_inc   = match_q + MATCH_ONE;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= HUNT;
            match_q     <= '0;
            cnt_q       <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            cnt_q       <= cnt_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (realign) begin
            state_d = HUNT;
            match_d = '0;
        end else if (boundary) begin
            case (state_q)
                HUNT: begin
                    if (pattern_hit) begin
                        match_d = MATCH_ONE;
                        state_d = (MATCH_ONE == MATCH_LOCK) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (pattern_hit) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_LOCK) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED:  state_d = LOCKED;
                default: begin
                    state_d = HUNT;
                    match_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en && !slip) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        end
        pix_valid_d = boundary && !realign && (state_q == LOCKED);
        pix_d       = pix_q;
        if (pix_valid_d) begin
            pix_d = lvds_unpack(word_w[LANE_A], word_w[LANE_B], word_w[LANE_C],
                                word_w[LANE_D][WORD_BITS-2:0]);
        end
    end

    assign R         = pix_q.r;
    assign G         = pix_q.g;
    assign B         = pix_q.b;
    assign hsync     = pix_q.hsync;
    assign vsync     = pix_q.vsync;
    assign data_en   = pix_q.data_en;
    assign pix_valid = pix_valid_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_lvds_data_deformatter.sv
// Self-checking bench for lvds_data_deformatter: randomized lanes against a
// bit-stream reference model (sample history + countdown to next word boundary).
module tb_lvds_data_deformatter;

    localparam int LOCK_N = 4;

    logic       clock   = 1'b0;
    logic       reset_L = 1'b0;
    logic       en      = 1'b0;
    logic [3:0] lane    = 4'h0;
    logic       train   = 1'b0;
    logic       realign = 1'b0;
    logic [7:0] R, G, B;
    logic       hsync, vsync, data_en, pix_valid, locked;

    lvds_data_deformatter #(.LOCK_COUNT(LOCK_N)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .en        (en),
        .lane      (lane),
        .train     (train),
        .realign   (realign),
        .R         (R),
        .G         (G),
        .B         (B),
        .hsync     (hsync),
        .vsync     (vsync),
        .data_en   (data_en),
        .pix_valid (pix_valid),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [3:0]  hist [$];     // every enabled sample, lane A in bit 3
    int          m_left;       // enabled bits until the next word boundary
    int          m_matches;    // 0 = hunting, LOCK_N = locked
    logic [26:0] m_out;        // {R,G,B,hsync,vsync,data_en}
    logic        m_valid;

    function automatic logic [6:0] lane_word(input int li);
        logic [6:0] w;
        logic [3:0] s;
        for (int k = 0; k < 7; k++) begin
            s = hist[hist.size() - 7 + k];
            w[6 - k] = s[li];
        end
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (7) hist.push_back(4'h0);
        m_left    = 7;
        m_matches = 0;
        m_out     = '0;
        m_valid   = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] ln, input logic e, input logic tr, input logic ra);
        logic       bnd;
        logic [6:0] wa, wb, wc, wd;
        bnd     = 1'b0;
        m_valid = 1'b0;
        if (e) begin
            hist.push_back(ln);
            if (hist.size() > 16) void'(hist.pop_front());
            m_left--;
            if (m_left == 0) begin
                bnd    = 1'b1;
                m_left = 7;
            end
        end
        if (ra) begin
            m_matches = 0;
        end else if (bnd) begin
            wa = lane_word(3); wb = lane_word(2); wc = lane_word(1); wd = lane_word(0);
            if (m_matches == LOCK_N) begin
                m_valid = 1'b1;
                m_out   = {wd[1:0], wa[5:0], wd[3:2], wb[4:0], wa[6],
                           wd[5:4], wc[3:0], wb[6:5], wc[4], wc[5], wc[6]};
            end else if (tr && wa == 7'b1100011) begin
                m_matches++;
            end else if (m_matches > 0) begin
                m_matches = 0;
            end else if (tr) begin
                m_left = 1;       // slip: boundary moves one bit later
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int gcyc       = 0;
    int pv_count   = 0;
    int last_pulse = 0;

    task automatic check_outputs();
        gcyc++;
        if (pix_valid === 1'b1) begin
            pv_count++;
            last_pulse = gcyc;
        end
        chk("locked", 32'(locked), 32'(m_matches == LOCK_N));
        chk("pix_valid", 32'(pix_valid), 32'(m_valid));
        chk("pixel", {5'd0, R, G, B, hsync, vsync, data_en}, {5'd0, m_out});
    endtask

    task automatic step(input logic [3:0] ln, input logic e, input logic tr, input logic ra);
        lane    = ln;
        en      = e;
        train   = tr;
        realign = ra;
        model_step(ln, e, tr, ra);
        @(negedge clock);
        check_outputs();
    endtask

    function automatic logic [27:0] encode(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b, input logic hs, input logic vs,
                                           input logic de, input logic dx);
        logic [6:0] a, bb, c, d;
        a  = {g[0], r[5:0]};
        bb = {b[1:0], g[5:1]};
        c  = {de, vs, hs, b[5:2]};
        d  = {dx, b[7:6], g[7:6], r[7:6]};
        return {a, bb, c, d};
    endfunction

    task automatic send_word(input logic [27:0] w, input logic tr, input int gap_at,
                             input int gap_len, input logic ra_last);
        logic [6:0] a, b, c, d;
        a = w[27:21]; b = w[20:14]; c = w[13:7]; d = w[6:0];
        for (int k = 6; k >= 0; k--) begin
            if (k == gap_at) repeat (gap_len) step(4'($urandom), 1'b0, tr, 1'b0);
            step({a[k], b[k], c[k], d[k]}, 1'b1, tr, ra_last && (k == 0));
        end
    endtask

    task automatic train_until_lock(input int pre_bits, output int lock_cyc);
        logic [6:0] pat;
        int         cyc;
        pat      = 7'b1100011;
        cyc      = 0;
        lock_cyc = -1;
        for (int i = 0; i < pre_bits; i++) begin
            step(4'($urandom), 1'b1, 1'b1, 1'b0);
            cyc++;
        end
        for (int w = 0; w < 12 && lock_cyc < 0; w++) begin
            for (int k = 6; k >= 0; k--) begin
                step({pat[k], 3'($urandom)}, 1'b1, 1'b1, 1'b0);
                cyc++;
                if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_cyc;
        int start;
        logic ph;

        // Reset hold with random inputs
        model_reset();
        repeat (20) begin
            lane  = 4'($urandom);
            en    = 1'($urandom);
            train = 1'($urandom);
            @(negedge clock);
            check_outputs();
        end
        reset_L = 1'b1;

        // Aligned training from phase 0
        train_until_lock(0, lock_cyc);
        chk("lock_aligned_cycles", 32'(lock_cyc), 32'd28);

        // realign on a locked word boundary, then idle with train=0
        pv_count = 0;
        send_word(encode(8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, -1, 0, 1'b1);
        chk("realign_unlock", 32'(locked), 32'd0);
        chk("realign_no_pixel", 32'(pv_count), 32'd0);
        repeat (40) step(4'($urandom), 1'b1, 1'b0, 1'b0);
        chk("hunt_stays_unlocked", 32'(locked), 32'd0);

        // Asynchronous reset mid-word
        repeat (3) step(4'($urandom), 1'b1, 1'b0, 1'b0);
        #2 reset_L = 1'b0;
        #1;
        chk("arst_pixel", {5'd0, R, G, B, hsync, vsync, data_en}, 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_pix_valid", 32'(pix_valid), 32'd0);
        model_reset();
        @(negedge clock);
        reset_L = 1'b1;

        // Misaligned training at offset 3: three slips, then four matches
        train_until_lock(3, lock_cyc);
        chk("lock_offset3_cycles", 32'(lock_cyc), 32'd31);

        // Directed pixel
        send_word(encode(8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, -1, 0, 1'b0);
        chk("dir_R", 32'(R), 32'hA5);
        chk("dir_G", 32'(G), 32'h3C);
        chk("dir_B", 32'(B), 32'hF0);
        chk("dir_ctl", {29'd0, hsync, vsync, data_en}, 32'b101);
        chk("dir_pix_valid", 32'(pix_valid), 32'd1);

        // Back-to-back black/white with random lane D bit 6
        pv_count = 0;
        for (int i = 0; i < 8; i++) begin
            ph = 1'(i);
            send_word(encode({8{ph}}, {8{ph}}, {8{ph}}, ph, ph, ph, 1'($urandom)), 1'b0, -1, 0, 1'b0);
            chk("b2b_R", 32'(R), ph ? 32'hFF : 32'h00);
        end
        chk("b2b_pulses", 32'(pv_count), 32'd8);

        // en gap of 5 cycles mid-word
        start = gcyc;
        send_word(encode(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom)), 1'b0, 3, 5, 1'b0);
        chk("gap_latency", 32'(last_pulse - start), 32'd12);

        // Random pixels, random gaps, random train (ignored while locked)
        for (int i = 0; i < 40; i++) begin
            send_word(encode(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                             1'($urandom), 1'($urandom)),
                      1'($urandom), $urandom_range(7) - 1, $urandom_range(3), 1'b0);
        end
        chk("random_still_locked", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lvds_data_deformatter.md
Name: lvds_data_deformatter

Overview:
- Receive-side counterpart of the panel LVDS formatter.
- Deserializes the four 7-bit-per-pixel serial lanes back into R/G/B (6-bit significant plus 2 MSBs), hsync, vsync and data_en.
- Finds the 7-bit word boundary with a training-pattern alignment FSM, then delivers one parallel pixel per word.
- Sits in loopback/verification builds and on the receive side of board-to-board links.

Parameters:
- WORD_BITS, 7, serial bits per lane per pixel; fixed by the lane map.
- ALIGN_PATTERN, 7'b1100011, word expected on lane A while train=1.
- LOCK_COUNT, 4, consecutive aligned pattern matches required to declare lock.

Ports:
- clock  in  1  bit clock (one serial bit per lane per enabled cycle)
- reset_L  in  1  asynchronous, active-low reset
- en  in  1  bit-enable; lanes sampled only when en=1
- lane  in  4  serial data: lane[3]=A, lane[2]=B, lane[1]=C, lane[0]=D
- train  in  1  transmitter is sending ALIGN_PATTERN on lane A
- realign  in  1  single-cycle pulse; drop lock and re-hunt
- R, G, B  out  8 each  recovered colour
- hsync, vsync, data_en  out  1 each  recovered control bits
- pix_valid  out  1  one-cycle strobe: outputs updated with a new pixel
- locked  out  1  word alignment established

Behaviour:
- Reset: all outputs 0; bit counter 0; shift registers 0; FSM in HUNT.
- Capture:
  - Per lane, a 7-bit left-shift register samples on posedge clock when en=1, MSB first: sr <= {sr[5:0], lane[i]}.
  - bit_cnt runs 0..6 when en=1 and wraps at 6.
- Word boundary:
  - Occurs on an en=1 cycle with bit_cnt==6.
  - The assembled word is {sr[5:0], lane[i]} of that same cycle.
- Lane map (word bit 6..0):
  - A = {G0, R5, R4, R3, R2, R1, R0}
  - B = {B1, B0, G5, G4, G3, G2, G1}
  - C = {data_en, vsync, hsync, B5, B4, B3, B2}
  - D = {don't-care, B7, B6, G7, G6, R7, R6}; D bit 6 is ignored.
- Output latency: pixel outputs are registered on the clock edge that completes the word and are visible the next cycle.
  - pix_valid is high for exactly that one cycle, and only while locked=1.
  - Pixel outputs hold their last value between words and while unlocked.
- FSM states: HUNT, VERIFY, LOCKED.
  - HUNT: at each word boundary with train=1:
    - lane A word == ALIGN_PATTERN -> VERIFY, match_cnt=1.
    - Otherwise bitslip: bit_cnt does not advance on that cycle, so the boundary moves one bit later. Repeated slips cover all 7 phases within 7 words + 7 slips.
  - HUNT with train=0: no slip; stay in HUNT.
  - VERIFY: at each boundary:
    - Match -> match_cnt++; reaching LOCK_COUNT -> LOCKED.
    - Mismatch, or train=0 -> HUNT, match_cnt=0.
  - LOCKED: locked=1; bit_cnt free-runs with no slips; train is ignored.
  - realign=1 in any state -> HUNT next cycle: locked=0, match_cnt=0, bit_cnt kept. realign takes priority over a simultaneous word boundary, and no pix_valid is produced for that word.
- en=0: every register holds, including the FSM, counters and shift registers; pix_valid=0.
- Reset mid-word: an asynchronous drop returns everything to reset values immediately; no partial pixel is emitted.
- Widths: bit_cnt is $clog2(WORD_BITS) bits; match_cnt is $clog2(LOCK_COUNT+1) bits and saturates at LOCK_COUNT.

Decomposition:
- Shared package lvds_pkg holds:
  - WORD_BITS and ALIGN_PATTERN constants
  - enum lvds_align_state_t {HUNT, VERIFY, LOCKED}
  - lane index constants LANE_A..LANE_D
- One natural sub-module, lvds_lane_deser: per-lane 7-bit shift register with word output, instantiated 4x.
- Counter and FSM live in the top.

Test Plan:
- Reset hold: reset_L=0 with random lanes for 20 cycles -> all outputs 0, locked=0, pix_valid never 1.
- Aligned training: train=1, lane A = 1100011 repeated from phase 0, en=1 -> locked rises after 4 words (28 bit-cycles + 1); no slips occur.
- Misaligned training at offset 3 -> 3 slips observed; locked=1 within 7*(3+4)+3 cycles. After lock, send pixel R=0xA5, G=0x3C, B=0xF0, hsync=1, vsync=0, de=1 -> one cycle after the 7th bit: R=0xA5, G=0x3C, B=0xF0, hsync=1, vsync=0, data_en=1, pix_valid=1 for exactly 1 cycle.
- Back-to-back pixels 0x000000 / 0xFFFFFF with controls 000/111 -> pix_valid every 7th cycle; outputs alternate; lane D bit 6 driven randomly has no effect.
- en gaps: insert en=0 for 5 cycles mid-word -> word reassembles correctly; pix_valid is delayed by 5 cycles.
- realign pulse while LOCKED on a word-boundary cycle -> locked=0 next cycle, no pix_valid; with train=0 the block stays in HUNT indefinitely.
